// File: rtl/jedro_1_dram_pkg.sv
// Shared types, write-enable constants and request-check helpers for the
// jedro_1 data-memory responder.
package jedro_1_dram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] WE_READ    = 4'b0000;
  localparam logic [3:0] WE_WORD    = 4'b1111;
  localparam logic [3:0] WE_HALF_LO = 4'b0011;
  localparam logic [3:0] WE_HALF_HI = 4'b1100;

  localparam int CNT_W = 4;

  // Bytes may sit anywhere, halves need addr[0]=0 and words need addr[1:0]=0.
  function automatic logic is_legal_we(input logic [3:0] we, input logic [1:0] addr_lo);
    logic legal;
    case (we)
      WE_READ:                             legal = 1'b1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000:  legal = 1'b1;
      WE_HALF_LO, WE_HALF_HI:              legal = ~addr_lo[0];
      WE_WORD:                             legal = (addr_lo == 2'b00);
      default:                             legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic in_range(input logic [63:0] addr, input logic [63:0] base,
                                    input int unsigned depth);
    return (addr >= base) && ((addr - base) < (64'(depth) << 2));
  endfunction

endpackage

// File: rtl/jedro_1_dram_bram.sv
// DEPTH_WORDS x 32 simple dual-port RAM: synchronous read, byte-lane writes.
module jedro_1_dram_bram #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic [3:0]       we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/jedro_1_dram.sv
// Responder end of the jedro_1 data-memory bus with range checking and
// programmable wait states. Optional macro: JEDRO_1_DRAM_ALIGN_CHECK_EN.
module jedro_1_dram_responder
  import jedro_1_dram_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stb_i,
  input  logic [3:0]            we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  output logic                  ack_o,
  output logic                  err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       req_we_q, req_we_d;
  logic [IDX_W-1:0] req_idx_q, req_idx_d;
  logic [31:0]      req_wdata_q, req_wdata_d;
  logic             req_err_q, req_err_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [IDX_W-1:0] addr_idx;
  logic             addr_err;
  logic             resp_active;
  logic [3:0]       ram_we;
  logic [IDX_W-1:0] ram_raddr;
  logic [31:0]      ram_rdata;

  assign addr_idx = IDX_W'((addr_i - ADDR_WIDTH'(BASE_ADDR)) >> 2);

  always_comb begin
    addr_err = ~in_range(64'(addr_i), 64'(BASE_ADDR), DEPTH_WORDS);
`ifdef JEDRO_1_DRAM_ALIGN_CHECK_EN
    if ((we_i != WE_READ) && !is_legal_we(we_i, addr_i[1:0])) addr_err = 1'b1;
`endif
  end

  // A reset landing on the RESP edge must suppress both the response and the write.
  assign resp_active = (state_q == RESP) && !rst_i;
  assign ack_o       = resp_active && !req_err_q;
  assign err_o       = resp_active && req_err_q;
  assign ram_we      = (resp_active && !req_err_q) ? req_we_q : WE_READ;

  // Present the live address while idle so zero-wait reads land in RESP.
  assign ram_raddr   = (state_q == IDLE) ? addr_idx : req_idx_q;

  jedro_1_dram_bram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_bram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (req_idx_q),
    .wdata_i (req_wdata_q),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_we_d    = req_we_q;
    req_idx_d   = req_idx_q;
    req_wdata_d = req_wdata_q;
    req_err_d   = req_err_q;
    rdata_d     = rdata_q;

    case (state_q)
      IDLE: begin
        if (stb_i) begin
          req_we_d    = we_i;
          req_idx_d   = addr_idx;
          req_wdata_d = wdata_i;
          req_err_d   = addr_err;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            cnt_d   = CNT_W'(WAIT_STATES - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (resp_active) begin
      if (req_err_q)                  rdata_d = '0;
      else if (req_we_q == WE_READ)   rdata_d = ram_rdata;
    end
  end

  assign rdata_o = rdata_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_we_q    <= WE_READ;
      req_idx_q   <= '0;
      req_wdata_q <= '0;
      req_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_we_q    <= req_we_d;
      req_idx_q   <= req_idx_d;
      req_wdata_q <= req_wdata_d;
      req_err_q   <= req_err_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_jedro_1_dram_responder.sv
// Scoreboard bench for jedro_1_dram_responder: three instances with 0, 3 and 2
// wait states; honours JEDRO_1_DRAM_ALIGN_CHECK_EN.
module tb_jedro_1_dram_responder;

  typedef struct {
    bit          err;
    bit          rchk;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  typedef struct {
    int          d;
    logic [3:0]  w;
    logic [31:0] a;
    logic [31:0] dat;
    bit          xerr;
    bit          rchk;
    logic [31:0] xrd;
    int          xlat;
  } req_t;

  logic        clk;
  logic        rst;
  logic        stb   [3];
  logic [3:0]  we    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        ack   [3];
  logic        err   [3];

  exp_t sb [$];
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    jedro_1_dram_responder #(
      .ADDR_WIDTH  (32),
      .DEPTH_WORDS (256),
      .BASE_ADDR   (32'h0000_1000),
      .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 3 : 2)
    ) u_dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .stb_i   (stb[g]),
      .we_i    (we[g]),
      .addr_i  (addr[g]),
      .wdata_i (wdata[g]),
      .rdata_o (rdata[g]),
      .ack_o   (ack[g]),
      .err_o   (err[g])
    );
  end

  // Called 1ns after a rising edge; returns 1ns after the edge that sampled stb.
  task automatic send(input int d, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] dat);
    stb[d]   = 1'b1;
    we[d]    = w;
    addr[d]  = a;
    wdata[d] = dat;
    @(posedge clk);
    #1;
    stb[d] = 1'b0;
    we[d]  = 4'b0000;
  endtask

  // Latency counts falling edges after the sampling edge; -1 means no response.
  task automatic wait_resp(input int d, input int maxc, output int lat,
                           output logic ak, output logic er, output logic [31:0] rd);
    lat = -1;
    ak  = 1'b0;
    er  = 1'b0;
    rd  = '0;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if (ack[d] === 1'b1 || err[d] === 1'b1) begin
        lat = k;
        ak  = ack[d];
        er  = err[d];
        rd  = rdata[d];
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_list(input string name, input req_t list [$]);
    int          lat;
    logic        ak, er;
    logic [31:0] rd;
    exp_t        ex;
    foreach (list[i]) begin
      sb.push_back('{err: list[i].xerr, rchk: list[i].rchk, rdata: list[i].xrd, lat: list[i].xlat});
      send(list[i].d, list[i].w, list[i].a, list[i].dat);
      wait_resp(list[i].d, 20, lat, ak, er, rd);
      ex = sb.pop_front();
      checks++;
      if (lat !== ex.lat) begin
        errors++;
        $display("[TB] FAIL %s[%0d] latency: got %0d want %0d", name, i, lat, ex.lat);
      end
      checks++;
      if ({ak, er} !== {~ex.err, ex.err}) begin
        errors++;
        $display("[TB] FAIL %s[%0d] ack/err: got %b%b want %b%b", name, i, ak, er, ~ex.err, ex.err);
      end
      if (ex.rchk) begin
        checks++;
        if (rd !== ex.rdata) begin
          errors++;
          $display("[TB] FAIL %s[%0d] rdata: got %08h want %08h", name, i, rd, ex.rdata);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      stb[d] = 1'b0; we[d] = '0; addr[d] = '0; wdata[d] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ack[d] !== 1'b0 || err[d] !== 1'b0 || rdata[d] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset dut%0d: ack=%b err=%b rdata=%08h want 0 0 0",
                 d, ack[d], err[d], rdata[d]);
      end
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    req_t l [$];
    l.push_back('{0, 4'b1111, 32'h1000, 32'hFFFF_FFFF, 0, 1, 32'h0, 1});
    l.push_back('{0, 4'b0000, 32'h1000, 32'h0, 0, 1, 32'hFFFF_FFFF, 1});
    run_list("basic", l);
  endtask

  task automatic test_wait_states();
    req_t        l [$];
    int          lat;
    logic        ak, er;
    logic [31:0] rd;
    exp_t        ex;
    l.push_back('{1, 4'b1111, 32'h1004, 32'h1234_5678, 0, 0, 32'h0, 4});
    run_list("ws_setup", l);
    // Measured from the ignored strobe, one edge after the real one.
    sb.push_back('{err: 0, rchk: 1, rdata: 32'h1234_5678, lat: 3});
    send(1, 4'b0000, 32'h1004, 32'h0);
    send(1, 4'b1111, 32'h1004, 32'hBAD0_BAD0);
    wait_resp(1, 20, lat, ak, er, rd);
    ex = sb.pop_front();
    checks++;
    if (lat !== ex.lat || ak !== 1'b1 || er !== 1'b0 || rd !== ex.rdata) begin
      errors++;
      $display("[TB] FAIL ws_read: lat=%0d ack=%b err=%b rdata=%08h want lat=%0d 1 0 %08h",
               lat, ak, er, rd, ex.lat, ex.rdata);
    end
    wait_resp(1, 8, lat, ak, er, rd);
    checks++;
    if (lat !== -1) begin
      errors++;
      $display("[TB] FAIL ws_extra_resp: got response at %0d want none", lat);
    end
    l.delete();
    l.push_back('{1, 4'b0000, 32'h1004, 32'h0, 0, 1, 32'h1234_5678, 4});
    run_list("ws_reread", l);
  endtask

  task automatic test_byte_lanes();
    req_t l [$];
    l.push_back('{0, 4'b1111, 32'h1008, 32'h0000_0000, 0, 0, 32'h0, 1});
    l.push_back('{0, 4'b0010, 32'h1008, 32'h0000_0F00, 0, 0, 32'h0, 1});
    l.push_back('{0, 4'b0000, 32'h1008, 32'h0, 0, 1, 32'h0000_0F00, 1});
    l.push_back('{0, 4'b1100, 32'h1008, 32'hABCD_0000, 0, 0, 32'h0, 1});
    l.push_back('{0, 4'b0000, 32'h100A, 32'h0, 0, 1, 32'hABCD_0F00, 1});
    run_list("lanes", l);
  endtask

  task automatic test_range();
    req_t l [$];
    l.push_back('{0, 4'b1111, 32'h13FC, 32'h5A5A_1234, 0, 0, 32'h0, 1});
    l.push_back('{0, 4'b0000, 32'h0FFC, 32'h0, 1, 1, 32'h0, 1});
    l.push_back('{0, 4'b1111, 32'h1400, 32'hDEAD_BEEF, 1, 1, 32'h0, 1});
    l.push_back('{0, 4'b0000, 32'h13FC, 32'h0, 0, 1, 32'h5A5A_1234, 1});
    run_list("range", l);
  endtask

  task automatic test_align();
    req_t l [$];
    l.push_back('{0, 4'b1111, 32'h1000, 32'h1111_1111, 0, 0, 32'h0, 1});
`ifdef JEDRO_1_DRAM_ALIGN_CHECK_EN
    l.push_back('{0, 4'b1111, 32'h1002, 32'h2222_2222, 1, 1, 32'h0, 1});
    l.push_back('{0, 4'b0000, 32'h1000, 32'h0, 0, 1, 32'h1111_1111, 1});
`else
    l.push_back('{0, 4'b1111, 32'h1002, 32'h2222_2222, 0, 0, 32'h0, 1});
    l.push_back('{0, 4'b0000, 32'h1000, 32'h0, 0, 1, 32'h2222_2222, 1});
`endif
    run_list("align", l);
  endtask

  task automatic test_reset_mid_op();
    req_t        l [$];
    int          lat;
    logic        ak, er;
    logic [31:0] rd;
    l.push_back('{2, 4'b1111, 32'h1010, 32'hCAFE_0001, 0, 0, 32'h0, 3});
    run_list("rst_setup", l);
    send(2, 4'b1111, 32'h1010, 32'hDEAD_0002);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_resp(2, 8, lat, ak, er, rd);
    checks++;
    if (lat !== -1) begin
      errors++;
      $display("[TB] FAIL rst_dropped: response at %0d ack=%b err=%b want none", lat, ak, er);
    end
    l.delete();
    l.push_back('{2, 4'b0000, 32'h1010, 32'h0, 0, 1, 32'hCAFE_0001, 3});
    run_list("rst_after", l);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_wait_states();
    test_byte_lanes();
    test_range();
    test_align();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
